// File: rtl/reg_file_operand_fetch.sv
// Operand-fetch sequencer for a two-read/one-write register file: drives read ports,
// forwards in-flight writebacks, and presents both operands on a valid/ready handshake.
module reg_file_operand_fetch #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [ADDR_WIDTH-1:0] rf_r1_addr,
  output logic [ADDR_WIDTH-1:0] rf_r2_addr,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic                  rf_write_ctrl,
  input  logic [DATA_WIDTH-1:0] rf_r1_out,
  input  logic [DATA_WIDTH-1:0] rf_r2_out,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, op_a_d, op_b_d;
  logic                  op_valid_q;
  logic                  accept;

  assign req_ready = (state_q == StIdle) || ((state_q == StValid) && op_ready);
  assign accept    = req_valid && req_ready;

  // Outside FETCH the request addresses go straight to the register file so the
  // acceptance edge doubles as its sample edge.
  assign rf_r1_addr = (state_q == StFetch) ? rs1_q : req_rs1;
  assign rf_r2_addr = (state_q == StFetch) ? rs2_q : req_rs2;

  assign rf_write_addr = wb_addr;
  assign rf_write_data = wb_data;
  assign rf_write_ctrl = wb_valid && reset_n && !(ZERO_REG && (wb_addr == '0));

  always_comb begin
    op_a_d = rf_r1_out;
    op_b_d = rf_r2_out;
    if (ZERO_REG && (rs1_q == '0)) begin
      op_a_d = '0;
    end else if (wb_valid && (wb_addr == rs1_q)) begin
      op_a_d = wb_data;
    end
    if (ZERO_REG && (rs2_q == '0)) begin
      op_b_d = '0;
    end else if (wb_valid && (wb_addr == rs2_q)) begin
      op_b_d = wb_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rs1_q      <= '0;
      rs2_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StFetch;
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
          end
        end
        StFetch: begin
          state_q    <= StValid;
          op_a_q     <= op_a_d;
          op_b_q     <= op_b_d;
          op_valid_q <= 1'b1;
        end
        StValid: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            if (req_valid) begin
              state_q <= StFetch;
              rs1_q   <= req_rs1;
              rs2_q   <= req_rs2;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q    <= StIdle;
          op_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;

endmodule

// File: tb/tb_reg_file_operand_fetch.sv
// Bench for reg_file_operand_fetch: behavioural register file, architectural-state model,
// a directed vector table, hand-written corner sequences and a randomized phase.
module tb_reg_file_operand_fetch;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_rs1, req_rs2;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] rf_r1_addr, rf_r2_addr, rf_write_addr;
  logic [DW-1:0] rf_write_data;
  logic          rf_write_ctrl;
  logic [DW-1:0] rf_r1_out, rf_r2_out;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;

  always #5 clock = ~clock;

  reg_file_operand_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .rf_write_ctrl(rf_write_ctrl),
    .rf_r1_out(rf_r1_out), .rf_r2_out(rf_r2_out),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b)
  );

  // Write-first register file with registered read data.
  logic [DW-1:0] rf_mem [256];
  always @(posedge clock) begin
    if (rf_write_ctrl) rf_mem[rf_write_addr] <= rf_write_data;
    rf_r1_out <= (rf_write_ctrl && rf_write_addr == rf_r1_addr) ? rf_write_data
                                                                : rf_mem[rf_r1_addr];
    rf_r2_out <= (rf_write_ctrl && rf_write_addr == rf_r2_addr) ? rf_write_data
                                                                : rf_mem[rf_r2_addr];
  end

  int checks = 0;
  int failures = 0;

  // Reference: architectural register values plus at most one fetch in flight and one
  // operand beat waiting downstream.
  logic [DW-1:0] arch [256];
  bit            inflight, pend, last_accept;
  logic [AW-1:0] f1, f2;
  logic [DW-1:0] pend_a, pend_b;
  bit            dut_acc;
  int            dut_beats = 0;

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return (a == '0) ? '0 : arch[a];
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h required=%02h t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already set; checks outputs, then advances the model
  // across the next rising edge and returns at the following negedge.
  task automatic cycle();
    bit m_ready;
    #1;
    m_ready = !inflight && (!pend || op_ready);
    chk1("req_ready", req_ready, m_ready);
    chk1("op_valid", op_valid, pend);
    if (pend) begin
      chk8("op_a", op_a, pend_a);
      chk8("op_b", op_b, pend_b);
    end
    chk1("wr_ctrl", rf_write_ctrl, wb_valid && reset_n && (wb_addr != '0));
    dut_acc = req_valid && req_ready;
    if (op_valid && op_ready) dut_beats++;
    @(posedge clock);
    if (!reset_n) begin
      inflight = 0; pend = 0; last_accept = 0;
    end else begin
      last_accept = req_valid && m_ready;
      if (wb_valid && wb_addr != '0) arch[wb_addr] = wb_data;
      if (inflight) begin
        pend = 1; pend_a = rd(f1); pend_b = rd(f2); inflight = 0;
      end else if (pend && op_ready) begin
        pend = 0;
      end
      if (last_accept) begin
        inflight = 1; f1 = req_rs1; f2 = req_rs2;
      end
    end
    @(negedge clock);
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1; wb_addr = a; wb_data = d;
    cycle();
    wb_valid = 0;
  endtask

  typedef struct {
    logic [AW-1:0] rs1, rs2;
    logic          fwd;
    logic [AW-1:0] fa;
    logic [DW-1:0] fd;
    logic [DW-1:0] ea, eb;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int n, b0;
    bit hold;
    for (int i = 0; i < 256; i++) begin rf_mem[i] = '0; arch[i] = '0; end
    inflight = 0; pend = 0; last_accept = 0;
    reset_n = 0; req_valid = 0; req_rs1 = 0; req_rs2 = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; op_ready = 0;

    vecs[0] = '{rs1: 8'd5, rs2: 8'd9, fwd: 0, fa: 8'd0, fd: 8'h00, ea: 8'h3C, eb: 8'hA1};
    vecs[1] = '{rs1: 8'd0, rs2: 8'd5, fwd: 0, fa: 8'd0, fd: 8'h00, ea: 8'h00, eb: 8'h3C};
    vecs[2] = '{rs1: 8'd7, rs2: 8'd7, fwd: 1, fa: 8'd7, fd: 8'h55, ea: 8'h55, eb: 8'h55};
    vecs[3] = '{rs1: 8'd9, rs2: 8'd0, fwd: 1, fa: 8'd0, fd: 8'hFF, ea: 8'hA1, eb: 8'h00};
    vecs[4] = '{rs1: 8'd5, rs2: 8'd7, fwd: 1, fa: 8'd5, fd: 8'h22, ea: 8'h22, eb: 8'h55};

    // Reset state
    @(negedge clock); @(negedge clock);
    chk1("rst_op_valid", op_valid, 1'b0);
    chk8("rst_op_a", op_a, 8'h00);
    chk8("rst_op_b", op_b, 8'h00);
    wb_valid = 1; wb_addr = 8'd3; wb_data = 8'h77;
    #1 chk1("rst_wr_ctrl", rf_write_ctrl, 1'b0);
    wb_valid = 0;
    @(negedge clock);
    reset_n = 1;
    cycle();

    wb_write(8'd5, 8'h3C);
    wb_write(8'd9, 8'hA1);
    wb_write(8'd7, 8'h11);
    wb_valid = 1; wb_addr = 8'd0; wb_data = 8'hFF;
    #1 chk1("zero_wr_ctrl", rf_write_ctrl, 1'b0);
    @(negedge clock);
    cycle();
    wb_valid = 0;

    // Directed table: accept, FETCH (optional writeback), then the beat.
    foreach (vecs[i]) begin
      req_valid = 1; req_rs1 = vecs[i].rs1; req_rs2 = vecs[i].rs2; op_ready = 0;
      cycle();
      req_valid = 0;
      wb_valid = vecs[i].fwd; wb_addr = vecs[i].fa; wb_data = vecs[i].fd;
      cycle();
      wb_valid = 0;
      chk1($sformatf("vec%0d_valid", i), op_valid, 1'b1);
      chk8($sformatf("vec%0d_a", i), op_a, vecs[i].ea);
      chk8($sformatf("vec%0d_b", i), op_b, vecs[i].eb);
      op_ready = 1;
      cycle();
      op_ready = 0;
    end

    // Backpressure with a writeback to a held operand's register.
    req_valid = 1; req_rs1 = 8'd5; req_rs2 = 8'd9;
    cycle();
    req_valid = 0;
    cycle();
    req_valid = 1; req_rs1 = 8'd5; req_rs2 = 8'd5;
    for (int i = 0; i < 4; i++) begin
      wb_valid = (i == 0); wb_addr = 8'd5; wb_data = 8'h99;
      cycle();
      chk8("bp_hold_a", op_a, 8'h22);
      chk1("bp_ready", req_ready, 1'b0);
    end
    wb_valid = 0; op_ready = 1;
    cycle();
    chk1("bp_release_accept", dut_acc, 1'b1);
    req_valid = 0; op_ready = 0;
    cycle();
    chk1("bp_next_valid", op_valid, 1'b1);
    chk8("bp_next_a", op_a, 8'h99);
    chk8("bp_next_b", op_b, 8'h99);
    op_ready = 1;
    cycle();

    // Back-to-back: six requests with op_ready held high.
    b0 = dut_beats; n = 0;
    for (int acc = 0; acc < 6 && n < 40; ) begin
      req_valid = 1; req_rs1 = 8'(acc + 3); req_rs2 = 8'(9 - acc);
      cycle();
      n++;
      if (dut_acc) acc++;
    end
    chk8("b2b_span", 8'(n), 8'd11);
    req_valid = 0;
    cycle(); cycle(); cycle();
    chk8("b2b_beats", 8'(dut_beats - b0), 8'd6);
    op_ready = 0;

    // Reset during FETCH.
    req_valid = 1; req_rs1 = 8'd5; req_rs2 = 8'd9;
    cycle();
    req_valid = 0;
    #2 reset_n = 0;
    #1 chk1("rst_fetch_valid", op_valid, 1'b0);
    inflight = 0; pend = 0;
    @(negedge clock);
    cycle();
    reset_n = 1;
    for (int i = 0; i < 3; i++) cycle();
    chk1("rst_fetch_ready", req_ready, 1'b1);

    // Reset while a beat is pending.
    req_valid = 1; req_rs1 = 8'd5; req_rs2 = 8'd9;
    cycle();
    req_valid = 0;
    cycle();
    #2 reset_n = 0;
    #1 chk1("rst_valid_valid", op_valid, 1'b0);
    chk8("rst_valid_a", op_a, 8'h00);
    chk8("rst_valid_b", op_b, 8'h00);
    inflight = 0; pend = 0;
    @(negedge clock);
    cycle();
    reset_n = 1;
    cycle();

    // Randomized traffic; a refused request is held unchanged.
    for (int i = 0; i < 400; i++) begin
      hold = req_valid && !last_accept;
      if (!hold) begin
        req_valid = ($urandom_range(0, 2) != 0);
        req_rs1 = 8'($urandom_range(0, 7));
        req_rs2 = 8'($urandom_range(0, 7));
      end
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_addr = 8'($urandom_range(0, 7));
      wb_data = 8'($urandom);
      op_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = 0; wb_valid = 0; op_ready = 1;
    for (int i = 0; i < 4; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
